// File: rtl/sd_ddr_pkg.sv
// Shared definitions for the SD-to-DDR write path: FSM encoding, MCB command code and
// the user-port geometry helper.
package sd_ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WORD = 3'd2,
        ST_CMD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;

    function automatic int bytes_per_word(input int port_w);
        return port_w / 8;
    endfunction

endpackage

// File: rtl/sd_byte_lane_packer.sv
// Collects SD bytes into one PORT_W-wide user-port word, lane by lane; a clear zeroes
// every lane so a short tail word leaves its unfilled lanes at 0.
module sd_byte_lane_packer
    import sd_ddr_pkg::*;
#(
    parameter int PORT_W    = 128,
    parameter bit BYTE_SWAP = 1'b0,
    localparam int BPW      = bytes_per_word(PORT_W),
    localparam int LANE_W   = $clog2(BPW) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [PORT_W-1:0] word,
    output logic              last_lane
);

    logic [PORT_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clear) begin
            word_d = '0;
            lane_d = '0;
        end else if (load) begin
            // With BYTE_SWAP the first byte of a word lands in the top lane.
            for (int i = 0; i < BPW; i++) begin
                if (lane_q == LANE_W'(BYTE_SWAP ? (BPW - 1 - i) : i)) begin
                    word_d[i*8 +: 8] = byte_in;
                end
            end
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word      = word_q;
    assign last_lane = (lane_q == LANE_W'(BPW - 1));

endmodule

// File: rtl/sd_ddr_burst_packer.sv
// SD byte stream to MCB write port: packs bytes into user-port words, pushes them into the
// write FIFO and issues one write command per burst, addresses running linearly from BASE_ADDR.
module sd_ddr_burst_packer
    import sd_ddr_pkg::*;
#(
    parameter int                PORT_W      = 128,
    parameter int                BURST_LEN   = 32,
    parameter int                ADDR_W      = 30,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_BYTES = 1572864,
    parameter bit                BYTE_SWAP   = 1'b0
) (
    input  logic                clk_50M,
    input  logic                reset_n,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                wr_en,
    output logic [PORT_W-1:0]   wr_data,
    output logic [PORT_W/8-1:0] wr_mask,
    input  logic                wr_full,
    output logic                cmd_en,
    output logic [2:0]          cmd_instr,
    output logic [5:0]          cmd_bl,
    output logic [ADDR_W-1:0]   cmd_byte_addr,
    input  logic                cmd_full,
    output logic                busy,
    output logic                frame_done,
    output logic                err_overflow
);

    localparam int BPW = bytes_per_word(PORT_W);

    state_t            state_q, state_d;
    logic [6:0]        burst_q, burst_d;
    logic [31:0]       fbytes_q, fbytes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic              pk_clear;
    logic              pk_load;
    logic              pk_last;
    logic              frame_end;
    logic [ADDR_W-1:0] addr_incr;

    sd_byte_lane_packer #(
        .PORT_W    (PORT_W),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_lane_packer (
        .clk       (clk_50M),
        .rst_n     (reset_n),
        .clear     (pk_clear),
        .load      (pk_load),
        .byte_in   (byte_data),
        .word      (wr_data),
        .last_lane (pk_last)
    );

    assign frame_end = (fbytes_q == 32'(FRAME_BYTES));
    assign addr_incr = ADDR_W'(burst_q) * ADDR_W'(BPW);

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        fbytes_d     = fbytes_q;
        addr_d       = addr_q;
        frame_done_d = frame_done_q;
        err_d        = err_q;
        pk_clear     = 1'b0;
        pk_load      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_FILL;
                    burst_d      = '0;
                    fbytes_d     = '0;
                    addr_d       = BASE_ADDR;
                    frame_done_d = 1'b0;
                    err_d        = 1'b0;
                    pk_clear     = 1'b1;
                end
            end
            ST_FILL: begin
                if (byte_valid) begin
                    pk_load  = 1'b1;
                    fbytes_d = fbytes_q + 32'd1;
                    if (pk_last || (fbytes_d == 32'(FRAME_BYTES))) begin
                        state_d = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (!wr_full) begin
                    pk_clear = 1'b1;
                    burst_d  = burst_q + 7'd1;
                    // The command follows its last data word, so the MCB never sees it early.
                    if ((burst_d == 7'(BURST_LEN)) || frame_end) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_CMD: begin
                if (!cmd_full) begin
                    addr_d  = addr_q + addr_incr;
                    burst_d = '0;
                    if (frame_end) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte offered outside FILL is lost; this wins over the clear done by start.
        if (byte_valid && (state_q != ST_FILL)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            burst_q      <= '0;
            fbytes_q     <= '0;
            addr_q       <= BASE_ADDR;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            fbytes_q     <= fbytes_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready    = (state_q == ST_FILL);
    assign busy          = (state_q == ST_FILL) || (state_q == ST_WORD) || (state_q == ST_CMD);
    assign wr_en         = (state_q == ST_WORD) && !wr_full;
    assign wr_mask       = '0;
    assign cmd_en        = (state_q == ST_CMD) && !cmd_full;
    assign cmd_instr     = CMD_WRITE;
    assign cmd_bl        = (state_q == ST_CMD) ? 6'(burst_q - 7'd1) : 6'd0;
    assign cmd_byte_addr = (state_q == ST_CMD) ? addr_q : '0;
    assign frame_done    = frame_done_q;
    assign err_overflow  = err_q;

endmodule

// File: tb/tb_sd_ddr_burst_packer.sv
// Bench for sd_ddr_burst_packer: two instances (40-byte frame, lane order normal; 64-byte
// frame, byte-swapped, non-zero base) checked against an event scoreboard.
`timescale 1ns/1ps
module tb_sd_ddr_burst_packer;

    localparam int PW = 128;
    localparam int AW = 30;

    logic          clk_50M = 1'b0;
    logic          reset_n;
    logic [1:0]    start, byte_valid, wr_full, cmd_full;
    logic [7:0]    byte_data [2];
    logic          byte_ready [2];
    logic          wr_en [2];
    logic [PW-1:0] wr_data [2];
    logic [PW/8-1:0] wr_mask [2];
    logic          cmd_en [2];
    logic [2:0]    cmd_instr [2];
    logic [5:0]    cmd_bl [2];
    logic [AW-1:0] cmd_addr [2];
    logic          busy [2];
    logic          frame_done [2];
    logic          err_overflow [2];

    always #10 clk_50M = ~clk_50M;

    sd_ddr_burst_packer #(
        .PORT_W(PW), .BURST_LEN(2), .ADDR_W(AW), .BASE_ADDR(30'h0),
        .FRAME_BYTES(40), .BYTE_SWAP(1'b0)
    ) u_dut0 (
        .clk_50M(clk_50M), .reset_n(reset_n), .start(start[0]),
        .byte_valid(byte_valid[0]), .byte_data(byte_data[0]), .byte_ready(byte_ready[0]),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]), .wr_mask(wr_mask[0]), .wr_full(wr_full[0]),
        .cmd_en(cmd_en[0]), .cmd_instr(cmd_instr[0]), .cmd_bl(cmd_bl[0]),
        .cmd_byte_addr(cmd_addr[0]), .cmd_full(cmd_full[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .err_overflow(err_overflow[0])
    );

    sd_ddr_burst_packer #(
        .PORT_W(PW), .BURST_LEN(2), .ADDR_W(AW), .BASE_ADDR(30'h1000),
        .FRAME_BYTES(64), .BYTE_SWAP(1'b1)
    ) u_dut1 (
        .clk_50M(clk_50M), .reset_n(reset_n), .start(start[1]),
        .byte_valid(byte_valid[1]), .byte_data(byte_data[1]), .byte_ready(byte_ready[1]),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]), .wr_mask(wr_mask[1]), .wr_full(wr_full[1]),
        .cmd_en(cmd_en[1]), .cmd_instr(cmd_instr[1]), .cmd_bl(cmd_bl[1]),
        .cmd_byte_addr(cmd_addr[1]), .cmd_full(cmd_full[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .err_overflow(err_overflow[1])
    );

    typedef struct {
        int            dut;
        bit            is_cmd;
        logic [PW-1:0] data;
        logic [AW-1:0] addr;
        logic [5:0]    bl;
    } ev_t;

    typedef struct {
        int         dut;
        logic [7:0] first;
        int         gap;
        int         exp_words;
        int         exp_cmds;
    } vec_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_words [2];
    int  n_cmds [2];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: expected words and commands of one whole frame, in issue order.
    task automatic push_frame(input int d, input logic [7:0] first);
        int            fb, nw, cnt, idx, pos;
        logic [AW-1:0] addr;
        logic [PW-1:0] word;
        ev_t           e;
        fb   = d ? 64 : 40;
        addr = d ? 30'h1000 : 30'h0;
        nw   = (fb + 15) / 16;
        cnt  = 0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int l = 0; l < 16; l++) begin
                idx = w * 16 + l;
                pos = d ? 15 - l : l;
                if (idx < fb) word[pos*8 +: 8] = first + 8'(idx);
            end
            e.dut = d; e.is_cmd = 1'b0; e.data = word; e.addr = '0; e.bl = '0;
            exp_q.push_back(e);
            cnt++;
            if (cnt == 2 || w == nw - 1) begin
                e.is_cmd = 1'b1; e.data = '0; e.addr = addr; e.bl = 6'(cnt - 1);
                exp_q.push_back(e);
                addr = addr + AW'(cnt * 16);
                cnt  = 0;
            end
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk_50M);
            for (int d = 0; d < 2; d++) begin
                if (wr_en[d] || cmd_en[d]) begin
                    checks++;
                    if (wr_en[d]) n_words[d]++;
                    else n_cmds[d]++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event dut%0d wr_en=%0b cmd_en=%0b", d, wr_en[d], cmd_en[d]);
                    end else begin
                        e = exp_q.pop_front();
                        if (wr_en[d]) begin
                            if (e.is_cmd || e.dut != d || wr_data[d] !== e.data || wr_mask[d] !== '0) begin
                                errors++;
                                $display("FAIL wr_word dut%0d got=%0h mask=%0h expected dut%0d cmd=%0b data=%0h",
                                         d, wr_data[d], wr_mask[d], e.dut, e.is_cmd, e.data);
                            end
                        end else begin
                            if (!e.is_cmd || e.dut != d || cmd_addr[d] !== e.addr || cmd_bl[d] !== e.bl
                                || cmd_instr[d] !== 3'b000) begin
                                errors++;
                                $display("FAIL wr_cmd dut%0d got addr=%0h bl=%0d instr=%0d expected dut%0d cmd=%0b addr=%0h bl=%0d",
                                         d, cmd_addr[d], cmd_bl[d], cmd_instr[d], e.dut, e.is_cmd, e.addr, e.bl);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic pulse_start(input int d);
        tick();
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic feed(input int d, input logic [7:0] first, input int from, input int n, input int gap);
        int i, idle, budget;
        i = from; idle = 0; budget = 0;
        while (i < from + n && budget < 3000) begin
            tick();
            budget++;
            if (idle > 0) begin
                byte_valid[d] = 1'b0;
                idle--;
            end else if (byte_ready[d]) begin
                byte_valid[d] = 1'b1;
                byte_data[d]  = first + 8'(i);
                i++;
                idle = gap;
            end else begin
                byte_valid[d] = 1'b0;
            end
        end
        tick();
        byte_valid[d] = 1'b0;
        if (i < from + n) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout dut%0d sent=%0d required=%0d", d, i - from, n);
        end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (frame_done[d] !== 1'b1 && n < 500) begin
            @(negedge clk_50M);
            n++;
        end
        chk("frame_done", PW'(frame_done[d]), PW'(1));
        chk("queue_drained", PW'(exp_q.size()), PW'(0));
    endtask

    task automatic run_frame(input int d, input logic [7:0] first, input int gap);
        push_frame(d, first);
        pulse_start(d);
        @(negedge clk_50M);
        chk("start_clears_done", PW'(frame_done[d]), PW'(0));
        chk("start_sets_busy", PW'(busy[d]), PW'(1));
        chk("start_clears_err", PW'(err_overflow[d]), PW'(0));
        feed(d, first, 0, d ? 64 : 40, gap);
        wait_done(d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        int   w0, c0;
        tbl[0] = '{0, 8'h00, 0, 3, 2};
        tbl[1] = '{1, 8'h00, 0, 4, 2};
        tbl[2] = '{0, 8'hA5, 2, 3, 2};
        tbl[3] = '{1, 8'hF0, 1, 4, 2};

        reset_n = 1'b0;
        start = '0; byte_valid = '0; wr_full = '0; cmd_full = '0;
        byte_data[0] = '0; byte_data[1] = '0;
        n_words[0] = 0; n_words[1] = 0; n_cmds[0] = 0; n_cmds[1] = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk_50M);
        for (int d = 0; d < 2; d++) begin
            chk("rst_byte_ready", PW'(byte_ready[d]), PW'(0));
            chk("rst_busy", PW'(busy[d]), PW'(0));
            chk("rst_frame_done", PW'(frame_done[d]), PW'(0));
            chk("rst_err", PW'(err_overflow[d]), PW'(0));
            chk("rst_wr_en", PW'(wr_en[d]), PW'(0));
            chk("rst_cmd_en", PW'(cmd_en[d]), PW'(0));
            chk("rst_wr_data", wr_data[d], PW'(0));
            chk("rst_cmd_addr", PW'(cmd_addr[d]), PW'(0));
        end
        tick();
        reset_n = 1'b1;

        // start and a byte together in IDLE: the byte is dropped and flagged.
        push_frame(0, 8'h00);
        tick();
        start[0] = 1'b1; byte_valid[0] = 1'b1; byte_data[0] = 8'hEE;
        tick();
        start[0] = 1'b0; byte_valid[0] = 1'b0;
        @(negedge clk_50M);
        chk("idle_start_byte_err", PW'(err_overflow[0]), PW'(1));
        feed(0, 8'h00, 0, 40, 0);
        wait_done(0);

        for (int t = 0; t < 4; t++) begin
            w0 = n_words[tbl[t].dut];
            c0 = n_cmds[tbl[t].dut];
            run_frame(tbl[t].dut, tbl[t].first, tbl[t].gap);
            chk("tbl_words", PW'(n_words[tbl[t].dut] - w0), PW'(tbl[t].exp_words));
            chk("tbl_cmds", PW'(n_cmds[tbl[t].dut] - c0), PW'(tbl[t].exp_cmds));
            chk("tbl_idle_after", PW'(busy[tbl[t].dut]), PW'(0));
        end

        // Write FIFO full while a word waits.
        push_frame(0, 8'h10);
        pulse_start(0);
        wr_full[0] = 1'b1;
        feed(0, 8'h10, 0, 16, 0);
        byte_valid[0] = 1'b1; byte_data[0] = 8'hEE;
        tick();
        byte_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_50M);
            chk("wr_stall_wr_en", PW'(wr_en[0]), PW'(0));
            chk("wr_stall_ready", PW'(byte_ready[0]), PW'(0));
        end
        chk("wr_stall_busy", PW'(busy[0]), PW'(1));
        chk("wr_stall_err", PW'(err_overflow[0]), PW'(1));
        tick();
        wr_full[0] = 1'b0;
        feed(0, 8'h10, 16, 24, 0);
        wait_done(0);

        // Command FIFO full while the first burst command waits.
        push_frame(1, 8'h40);
        pulse_start(1);
        cmd_full[1] = 1'b1;
        feed(1, 8'h40, 0, 32, 0);
        repeat (3) tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_50M);
            chk("cmd_stall_en", PW'(cmd_en[1]), PW'(0));
            chk("cmd_stall_bl", PW'(cmd_bl[1]), PW'(1));
            chk("cmd_stall_addr", PW'(cmd_addr[1]), PW'(30'h1000));
        end
        tick();
        cmd_full[1] = 1'b0;
        feed(1, 8'h40, 32, 32, 0);
        wait_done(1);

        // start while busy is ignored.
        push_frame(0, 8'h80);
        pulse_start(0);
        feed(0, 8'h80, 0, 8, 0);
        pulse_start(0);
        @(negedge clk_50M);
        chk("busy_start_ignored", PW'(busy[0]), PW'(1));
        feed(0, 8'h80, 8, 32, 0);
        wait_done(0);

        // Reset in the middle of a frame abandons it.
        push_frame(1, 8'h00);
        pulse_start(1);
        feed(1, 8'h00, 0, 20, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", PW'(busy[1]), PW'(0));
        chk("midrst_ready", PW'(byte_ready[1]), PW'(0));
        chk("midrst_wr_en", PW'(wr_en[1]), PW'(0));
        chk("midrst_cmd_en", PW'(cmd_en[1]), PW'(0));
        chk("midrst_wr_data", wr_data[1], PW'(0));
        chk("midrst_cmd_addr", PW'(cmd_addr[1]), PW'(0));
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        run_frame(1, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
